// File: rtl/led_shifter_paged.sv
// Paged LED bit-shifter: button edges push bits into a PAGES*WIDTH history,
// undo pops the newest bit, and history mode pages through the stored bits.
module led_shifter_paged #(
  parameter int WIDTH        = 8,
  parameter int PAGES        = 2,
  parameter int PAGE_CYCLES  = 50_000_000,
  parameter int BLANK_CYCLES = 25_000_000,
  localparam int N  = PAGES * WIDTH,
  localparam int FW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             button0_re,
  input  logic             button1_re,
  input  logic             undo_re,
  input  logic             show_parity,
  input  logic             show_history,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       hex,
  output logic [FW-1:0]    fill
);

  localparam int PW   = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CMAX = (PAGE_CYCLES > BLANK_CYCLES) ? PAGE_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] PAGE_LAST  = CW'(PAGE_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PAGE  = PW'(PAGES - 1);
  localparam logic [FW-1:0] FILL_MAX   = FW'(N);

  typedef enum logic [1:0] {EDIT, PAGE, BLANK} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   page_q, page_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
    return (f == FILL_MAX) ? f : f + FW'(1);
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    case (state_q)
      EDIT: begin
        if (show_history) begin
          state_d = PAGE;
          page_d  = '0;
          cnt_d   = '0;
        end else begin
          // Only a lone event acts; simultaneous pulses cancel each other out.
          case ({button0_re, button1_re, undo_re})
            3'b100, 3'b010: begin
              hist_d = {hist_q[N-2:0], button1_re};
              fill_d = fill_sat_inc(fill_q);
            end
            3'b001: begin
              if (fill_q != '0) begin
                hist_d = {1'b0, hist_q[N-1:1]};
                fill_d = fill_q - FW'(1);
              end
            end
            default: ;
          endcase
        end
      end
      PAGE: begin
        if (!show_history) begin
          state_d = EDIT;
          page_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == PAGE_LAST) begin
          cnt_d = '0;
          if (page_q == LAST_PAGE) begin
            state_d = BLANK;
            page_d  = '0;
          end else begin
            page_d = page_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BLANK: begin
        if (!show_history) begin
          state_d = EDIT;
          page_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = PAGE;
          page_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q <= EDIT;
      hist_q  <= '0;
      fill_q  <= '0;
      page_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out = '0;
    case (state_q)
      EDIT: out = hist_q[WIDTH-1:0];
      PAGE: begin
        for (int p = 0; p < PAGES; p++) begin
          if (page_q == p[PW-1:0]) out = hist_q[p*WIDTH +: WIDTH];
        end
      end
      default: out = '0;
    endcase
  end

  // Parity always refers to page 0, regardless of which page is on the LEDs.
  always_comb begin
    hex = 8'h00;
    if (show_parity)          hex = (^hist_q[WIDTH-1:0]) ? 8'h06 : 8'h3F;
    else if (state_q == PAGE) hex = seg7(4'(page_q));
  end

  assign fill = fill_q;

endmodule

// File: tb/tb_led_shifter_paged.sv
// Bench for led_shifter_paged: directed scenarios plus random pulses, checked
// against a queue-based history model and an arithmetic paging-timeline model.
module tb_led_shifter_paged;
  localparam int WIDTH = 8, PAGES = 2, PC = 4, BC = 2;
  localparam int N = PAGES * WIDTH;
  localparam int FW = $clog2(N + 1);

  logic clk = 1'b0, async_nreset = 1'b0;
  logic button0_re = 1'b0, button1_re = 1'b0, undo_re = 1'b0;
  logic show_parity = 1'b0, show_history = 1'b0;
  logic [WIDTH-1:0] out;
  logic [7:0] hex;
  logic [FW-1:0] fill;

  led_shifter_paged #(.WIDTH(WIDTH), .PAGES(PAGES), .PAGE_CYCLES(PC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .async_nreset(async_nreset), .button0_re(button0_re),
    .button1_re(button1_re), .undo_re(undo_re), .show_parity(show_parity),
    .show_history(show_history), .out(out), .hex(hex), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit q[$];        // q[0] = newest stored bit
  bit m_paging = 0;
  int m_t = 0;     // cycles spent in history mode
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] m_word(input int pg);
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pg * WIDTH + i < q.size()) w[i] = q[pg * WIDTH + i];
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] m_out();
    int ph;
    if (!m_paging) return m_word(0);
    ph = m_t % (PAGES * PC + BC);
    return (ph < PAGES * PC) ? m_word(ph / PC) : '0;
  endfunction

  function automatic logic [7:0] m_hex();
    int ph;
    if (show_parity) return (^m_word(0)) ? 8'h06 : 8'h3F;
    if (!m_paging) return 8'h00;
    ph = m_t % (PAGES * PC + BC);
    return (ph < PAGES * PC) ? seg_tab[ph / PC] : 8'h00;
  endfunction

  task automatic model_step();
    int nev = int'(button0_re) + int'(button1_re) + int'(undo_re);
    if (!m_paging) begin
      if (show_history) begin
        m_paging = 1; m_t = 0;
      end else if (nev == 1) begin
        if (undo_re) begin
          if (q.size() > 0) void'(q.pop_front());
        end else begin
          q.push_front(button1_re);
          if (q.size() > N) void'(q.pop_back());
        end
      end
    end else begin
      if (!show_history) begin
        m_paging = 0; m_t = 0;
      end else m_t++;
    end
  endtask

  task automatic cyc(input bit b0, input bit b1, input bit u);
    @(negedge clk);
    button0_re = b0; button1_re = b1; undo_re = u;
    model_step();
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(m_out()));
    check("fill", 32'(fill), q.size());
    check("hex", 32'(hex), 32'(m_hex()));
    button0_re = 0; button1_re = 0; undo_re = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    show_history = 0; show_parity = 0;
    async_nreset = 0;
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_hex", 32'(hex), 0);
    @(negedge clk);
    async_nreset = 1;
    q.delete(); m_paging = 0; m_t = 0;
  endtask

  logic [15:0] pat;
  logic [7:0] exp_seq [11] = '{8'h34, 8'h34, 8'h34, 8'h34, 8'h12, 8'h12, 8'h12, 8'h12, 8'h00, 8'h00, 8'h34};

  initial begin
    do_reset();
    // 1: b1,b0,b1,b1
    cyc(0, 1, 0); cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    show_parity = 1; #1;
    check("t1_out", 32'(out), 32'h0B);
    check("t1_fill", 32'(fill), 4);
    check("t1_hex", 32'(hex), 32'h06);
    show_parity = 0;
    // 2: 18 alternating pulses, saturating fill
    for (int i = 0; i < 18; i++) cyc(i % 2 == 1, i % 2 == 0, 0);
    check("t2_out", 32'(out), 32'hAA);
    check("t2_fill", 32'(fill), 16);
    // 3: 9 ones then undo, then undo down to empty and once more
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    check("t3_out", 32'(out), 32'hFF);
    check("t3_fill", 32'(fill), 8);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);
    check("t3_empty_fill", 32'(fill), 0);
    check("t3_empty_out", 32'(out), 0);
    // 4: simultaneous pulses ignored
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    check("t4_out", 32'(out), 32'h03);
    check("t4_fill", 32'(fill), 2);
    // 5: load 16'h1234 and page through it
    do_reset();
    pat = 16'h1234;
    for (int i = 15; i >= 0; i--) cyc(!pat[i], pat[i], 0);
    show_history = 1;
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 0);
      check("t5_seq", 32'(out), 32'(exp_seq[i]));
    end
    // 6: b1 during paging ignored, drop history mid-page
    cyc(0, 1, 0);
    show_history = 0;
    cyc(0, 0, 0);
    check("t6_edit_out", 32'(out), 32'h34);
    check("t6_fill", 32'(fill), 16);
    show_history = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    #2 async_nreset = 0;
    #1;
    check("t6_async_out", 32'(out), 0);
    check("t6_async_fill", 32'(fill), 0);
    @(negedge clk);
    show_history = 0;
    async_nreset = 1;
    q.delete(); m_paging = 0; m_t = 0;
    // random phase
    for (int i = 0; i < 600; i++) begin
      show_parity = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) show_history = ~show_history;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, checks %0d", n_chk);
    $fatal(1);
  end
endmodule
